vector_checker: RTL and testbench

VECTOR_CHECKER -- requirements
Module: vector_checker

---
 rtl/vector_checker.sv | 145 ++++++++++++++
 tb/tb_vector_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_checker.sv
// Streams test vectors into a clocked DUT, compares its output LAT cycles later,
// and reports mismatches with saturating retired-vector and error counters.
module vector_checker #(
  parameter int WIDTH = 16,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               vec_valid,
  output logic               vec_ready,
  input  logic [2*WIDTH:0]   vec_data,
  input  logic               vec_last,
  output logic               dut_reset,
  output logic [WIDTH-1:0]   dut_d,
  input  logic [WIDTH-1:0]   dut_q,
  output logic               err_valid,
  output logic [WIDTH-1:0]   err_got,
  output logic [WIDTH-1:0]   err_exp,
  output logic [CNT_W-1:0]   vec_count,
  output logic [CNT_W-1:0]   err_count,
  output logic               busy,
  output logic               done
);

  localparam int DEPTH = LAT + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state_q, state_d;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0]             chk_q, chk_d;
  logic [DEPTH-1:0][WIDTH-1:0]  exp_q, exp_d;
  logic                         dut_reset_q, dut_reset_d;
  logic [WIDTH-1:0]             dut_d_q, dut_d_d;
  logic                         err_valid_q, err_valid_d;
  logic [WIDTH-1:0]             err_got_q, err_got_d;
  logic [WIDTH-1:0]             err_exp_q, err_exp_d;
  logic [CNT_W-1:0]             vec_count_q, vec_count_d;
  logic [CNT_W-1:0]             err_count_q, err_count_d;

  logic             in_vrst;
  logic [WIDTH-1:0] in_d;
  logic [WIDTH-1:0] in_exp;
  logic             handshake;
  logic             retire;
  logic             mismatch;
  logic             clear;

  assign in_vrst   = vec_data[2*WIDTH];
  assign in_d      = vec_data[2*WIDTH-1:WIDTH];
  assign in_exp    = vec_data[WIDTH-1:0];
  assign handshake = vec_valid && (state_q == RUN);
  assign retire    = vld_q[DEPTH-1];
  assign mismatch  = retire && chk_q[DEPTH-1] && (dut_q != exp_q[DEPTH-1]);
  assign clear     = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d     = state_q;
    dut_reset_d = dut_reset_q;
    dut_d_d     = dut_d_q;
    err_valid_d = mismatch;
    err_got_d   = err_got_q;
    err_exp_d   = err_exp_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    // Tokens shift every cycle; a cycle without a handshake injects a bubble.
    vld_d       = {vld_q[DEPTH-2:0], handshake};
    chk_d       = {chk_q[DEPTH-2:0], ~in_vrst};
    exp_d       = {exp_q[DEPTH-2:0], in_exp};

    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (handshake && vec_last) state_d = DRAIN;
      DRAIN: begin
        if (vld_q == '0) begin
          state_d     = DONE;
          dut_reset_d = 1'b1;
        end
      end
      default:    state_d = IDLE;
    endcase

    if (handshake) begin
      dut_reset_d = in_vrst;
      dut_d_d     = in_d;
    end

    if (retire && (vec_count_q != '1)) vec_count_d = vec_count_q + CNT_W'(1);
    if (mismatch) begin
      err_got_d = dut_q;
      err_exp_d = exp_q[DEPTH-1];
      if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
    end

    // The pipeline is empty in IDLE/DONE, so clearing never races a retirement.
    if (clear) begin
      vec_count_d = '0;
      err_count_d = '0;
      err_got_d   = '0;
      err_exp_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      vld_q       <= '0;
      chk_q       <= '0;
      exp_q       <= '0;
      dut_reset_q <= 1'b1;
      dut_d_q     <= '0;
      err_valid_q <= 1'b0;
      err_got_q   <= '0;
      err_exp_q   <= '0;
      vec_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      chk_q       <= chk_d;
      exp_q       <= exp_d;
      dut_reset_q <= dut_reset_d;
      dut_d_q     <= dut_d_d;
      err_valid_q <= err_valid_d;
      err_got_q   <= err_got_d;
      err_exp_q   <= err_exp_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign vec_ready = (state_q == RUN);
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign dut_reset = dut_reset_q;
  assign dut_d     = dut_d_q;
  assign err_valid = err_valid_q;
  assign err_got   = err_got_q;
  assign err_exp   = err_exp_q;
  assign vec_count = vec_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_vector_checker.sv
// Scoreboard bench: two checkers (16-bit and 2-bit counters) share stimulus,
// each driving its own DFF DUT; expected mismatches are queued and popped on err_valid.
module tb_vector_checker;

  localparam int WIDTH = 16;
  localparam int LAT   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, start, vec_valid, vec_last;
  logic [2*WIDTH:0]  vec_data;

  logic              vec_ready, dut_reset, err_valid, busy, done;
  logic [WIDTH-1:0]  dut_d, dut_q, err_got, err_exp;
  logic [15:0]       vec_count, err_count;

  logic              s_vec_ready, s_dut_reset, s_err_valid, s_busy, s_done;
  logic [WIDTH-1:0]  s_dut_d, s_dut_q, s_err_got, s_err_exp;
  logic [1:0]        s_vec_count, s_err_count;

  vector_checker #(.WIDTH(WIDTH), .LAT(LAT), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_data(vec_data), .vec_last(vec_last),
    .dut_reset(dut_reset), .dut_d(dut_d), .dut_q(dut_q),
    .err_valid(err_valid), .err_got(err_got), .err_exp(err_exp),
    .vec_count(vec_count), .err_count(err_count), .busy(busy), .done(done)
  );

  vector_checker #(.WIDTH(WIDTH), .LAT(LAT), .CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .start(start), .vec_valid(vec_valid),
    .vec_ready(s_vec_ready), .vec_data(vec_data), .vec_last(vec_last),
    .dut_reset(s_dut_reset), .dut_d(s_dut_d), .dut_q(s_dut_q),
    .err_valid(s_err_valid), .err_got(s_err_got), .err_exp(s_err_exp),
    .vec_count(s_vec_count), .err_count(s_err_count), .busy(s_busy), .done(s_done)
  );

  // Device under check: a plain 16-bit DFF with active-high synchronous reset.
  always @(posedge clk) dut_q   <= dut_reset   ? '0 : dut_d;
  always @(posedge clk) s_dut_q <= s_dut_reset ? '0 : s_dut_d;

  typedef struct {
    logic [WIDTH-1:0] got;
    logic [WIDTH-1:0] expv;
    int               cyc;
  } err_t;

  err_t             sb[$];
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  int               exp_vec, exp_err, s_pulses;
  logic [WIDTH-1:0] last_got, last_exp;

  logic             v_rst [16];
  logic [WIDTH-1:0] v_d   [16];
  logic [WIDTH-1:0] v_e   [16];
  int               v_gap [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Monitor: every err_valid pulse must match the oldest expected mismatch.
  always @(negedge clk) begin
    if (s_err_valid) s_pulses++;
    if (err_valid) begin
      if (sb.size() == 0) begin
        check_output("unexpected_err_valid", 1, 0);
      end else begin
        err_t e;
        e = sb.pop_front();
        check_output("err_got", err_got, e.got);
        check_output("err_exp", err_exp, e.expv);
        check_output("err_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic check_reset_values();
    check_output("rst_vec_ready", vec_ready, 0);
    check_output("rst_dut_reset", dut_reset, 1);
    check_output("rst_dut_d", dut_d, 0);
    check_output("rst_err_valid", err_valid, 0);
    check_output("rst_err_got", err_got, 0);
    check_output("rst_err_exp", err_exp, 0);
    check_output("rst_vec_count", vec_count, 0);
    check_output("rst_err_count", err_count, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_small_count", {s_vec_count, s_err_count}, 0);
    check_output("rst_small_ctrl", {s_vec_ready, s_dut_reset}, 2'b01);
  endtask

  task automatic send_vector(input logic vrst, input logic [WIDTH-1:0] d,
                             input logic [WIDTH-1:0] e, input logic last, input int gap);
    vec_valid = 1'b0;
    repeat (gap) @(negedge clk);
    vec_valid = 1'b1;
    vec_data  = {vrst, d, e};
    vec_last  = last;
    check_output("vec_ready", vec_ready, 1);
    exp_vec++;
    if (!vrst && (d != e)) begin
      exp_err++;
      last_got = d;
      last_exp = e;
      sb.push_back('{got: d, expv: e, cyc: cyc + LAT + 2});
    end
    @(negedge clk);
    vec_valid = 1'b0;
    vec_last  = 1'b0;
    check_output("hs_dut_reset", dut_reset, vrst);
    check_output("hs_dut_d", dut_d, d);
  endtask

  task automatic start_run();
    exp_vec  = 0;
    exp_err  = 0;
    s_pulses = 0;
    last_got = '0;
    last_exp = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("run_busy", busy, 1);
    check_output("run_cleared", {vec_count, err_count}, 0);
  endtask

  task automatic apply_stimulus(input int n);
    int w;
    start_run();
    for (int i = 0; i < n; i++) send_vector(v_rst[i], v_d[i], v_e[i], i == n - 1, v_gap[i]);
    w = 0;
    while (!done && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_output("done", done, 1);
    check_output("done_latency", (w >= LAT + 2) ? 1 : 0, 1);
    check_output("done_busy", busy, 0);
    check_output("done_dut_reset", dut_reset, 1);
    check_output("vec_count", vec_count, exp_vec);
    check_output("err_count", err_count, exp_err);
    check_output("err_got_hold", err_got, last_got);
    check_output("err_exp_hold", err_exp, last_exp);
    check_output("small_vec_count", s_vec_count, sat3(exp_vec));
    check_output("small_err_count", s_err_count, sat3(exp_err));
    check_output("small_pulses", s_pulses, exp_err);
    check_output("small_done", {s_done, s_busy}, 2'b10);
    check_output("small_err_got", {s_err_got, s_err_exp}, {last_got, last_exp});
    check_output("sb_empty", sb.size(), 0);
  endtask

  task automatic load(input int i, input logic r, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] e, input int gap);
    v_rst[i] = r;
    v_d[i]   = d;
    v_e[i]   = e;
    v_gap[i] = gap;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0; vec_data = '0;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] clean run");
    load(0, 0, 16'h1234, 16'h0000, 0);
    load(1, 0, 16'hABCD, 16'h1234, 0);
    load(2, 0, 16'h0000, 16'hABCD, 0);
    apply_stimulus(3);

    $display("[TB] single mismatch");
    load(2, 0, 16'h0000, 16'hABCE, 0);
    apply_stimulus(3);

    $display("[TB] reset vector");
    load(0, 1, 16'hFFFF, 16'h5555, 0);
    load(1, 0, 16'h1357, 16'h1357, 0);
    apply_stimulus(2);

    $display("[TB] bubbles");
    load(0, 0, 16'h0F0F, 16'h0F0F, 0);
    load(1, 0, 16'h3C3C, 16'h3C3D, 2);
    apply_stimulus(2);

    $display("[TB] saturation");
    for (int i = 0; i < 5; i++) load(i, 0, 16'(i * 16'h1111), ~16'(i * 16'h1111), 0);
    apply_stimulus(5);

    $display("[TB] one-vector run");
    load(0, 0, 16'hBEEF, 16'hBEE0, 1);
    apply_stimulus(1);

    $display("[TB] abort");
    start_run();
    send_vector(0, 16'h1111, 16'h2222, 0, 0);
    send_vector(0, 16'h3333, 16'h4444, 0, 0);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_values();
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check_output("abort_counts", {vec_count, err_count}, 0);

    $display("[TB] random runs");
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) begin
        logic [WIDTH-1:0] d;
        d = WIDTH'($urandom);
        load(i, ($urandom_range(7) == 0) ? 1'b1 : 1'b0, d,
             ($urandom_range(2) == 0) ? WIDTH'($urandom) : d, $urandom_range(2));
      end
      apply_stimulus(n);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
